// File: rtl/tcdm_mpu_filter_if.sv
// Per-port TCDM request/response bundle. The filter uses "slave" toward the
// upstream masters and "master" toward the interconnect.
interface tcdm_mpu_filter_if #(
  parameter int unsigned N_PORTS    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
);
  logic [N_PORTS-1:0]            req;
  logic [N_PORTS*ADDR_WIDTH-1:0] add;
  logic [N_PORTS-1:0]            wen;
  logic [N_PORTS*DATA_WIDTH-1:0] wdata;
  logic [N_PORTS*BE_WIDTH-1:0]   be;
  logic [N_PORTS-1:0]            gnt;
  logic [N_PORTS*DATA_WIDTH-1:0] r_rdata;
  logic [N_PORTS-1:0]            r_valid;

  modport master (output req, add, wen, wdata, be, input  gnt, r_rdata, r_valid);
  modport slave  (input  req, add, wen, wdata, be, output gnt, r_rdata, r_valid);
endinterface

// File: rtl/tcdm_mpu_filter.sv
// Rule-table address filter for N_PORTS TCDM masters with fault logging.
// Define TCDM_MPU_PORT_CNT_EN to add per-port violation counters at 0xF10+4p.
module tcdm_mpu_filter #(
  parameter int unsigned N_PORTS       = 4,
  parameter int unsigned N_RULES       = 8,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned BE_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned GRAN_LOG2     = 6,
  parameter logic [31:0] ERR_PATTERN   = 32'hBADE5505,
  parameter logic        FILTER_EN_RST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_PORTS-1:0]   supervisor_mode_i,
  tcdm_mpu_filter_if.slave     mst_bus,
  tcdm_mpu_filter_if.master    slv_bus,
  input  logic                 cfg_req_i,
  input  logic [11:0]          cfg_add_i,
  input  logic                 cfg_wen_i,
  input  logic [31:0]          cfg_wdata_i,
  output logic                 cfg_gnt_o,
  output logic [31:0]          cfg_r_rdata_o,
  output logic                 cfg_r_valid_o,
  output logic                 err_irq_o
);
  localparam int unsigned CMP_W = ADDR_WIDTH - GRAN_LOG2;

  logic [31:0] start_q [N_RULES], start_d [N_RULES];
  logic [31:0] end_q   [N_RULES], end_d   [N_RULES];
  logic [3:0]  ctrl_q  [N_RULES], ctrl_d  [N_RULES];
  logic        filter_en_q, filter_en_d;
  logic        err_valid_q, err_valid_d, err_wen_q, err_wen_d;
  logic [3:0]  err_port_q, err_port_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [15:0] err_count_q, err_count_d;
  logic [N_PORTS-1:0] err_pend_q, allow_s, viol_s;
  logic        cfg_r_valid_q;
  logic [31:0] cfg_rdata_q, cfg_rdata_s;
  logic        cfg_we_s, glb_sel_s, err_clr_s, unused_s;
  logic [5:0]  glb_word_s;
  logic [3:0]  first_port_s;
  logic [31:0] first_addr_s;
  logic        first_wen_s;
  logic [4:0]  viol_cnt_s;
  logic [16:0] count_sum_s;
`ifdef TCDM_MPU_PORT_CNT_EN
  logic [15:0] pcnt_q [N_PORTS], pcnt_d [N_PORTS];
`endif

  assign cfg_we_s   = cfg_req_i & ~cfg_wen_i;
  assign glb_sel_s  = (cfg_add_i[11:8] == 4'hF);
  assign glb_word_s = cfg_add_i[7:2];
  assign err_clr_s  = cfg_we_s & glb_sel_s & (glb_word_s == 6'd2);
  assign unused_s   = ^cfg_add_i[1:0];

  // Rule matching and violation detection per port
  always_comb begin
    allow_s = '0;
    viol_s  = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      allow_s[p] = ~filter_en_q | supervisor_mode_i[p];
      for (int r = 0; r < N_RULES; r++) begin
        allow_s[p] = allow_s[p] | (ctrl_q[r][0]
          & (start_q[r][ADDR_WIDTH-1:GRAN_LOG2] <= mst_bus.add[p*ADDR_WIDTH+GRAN_LOG2 +: CMP_W])
          & (mst_bus.add[p*ADDR_WIDTH+GRAN_LOG2 +: CMP_W] < end_q[r][ADDR_WIDTH-1:GRAN_LOG2])
          & (mst_bus.wen[p] ? ctrl_q[r][1] : ctrl_q[r][2]));
      end
      viol_s[p] = mst_bus.req[p] & ~allow_s[p];
    end
  end

  assign slv_bus.req   = mst_bus.req & ~viol_s;
  assign slv_bus.add   = mst_bus.add;
  assign slv_bus.wen   = mst_bus.wen;
  assign slv_bus.wdata = mst_bus.wdata;
  assign slv_bus.be    = mst_bus.be[N_PORTS*BE_WIDTH-1:0];
  assign mst_bus.gnt   = slv_bus.gnt | viol_s;
  assign mst_bus.r_valid = slv_bus.r_valid | err_pend_q;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_rdata
    assign mst_bus.r_rdata[p*DATA_WIDTH +: DATA_WIDTH] = err_pend_q[p]
      ? {(DATA_WIDTH/32){ERR_PATTERN}} : slv_bus.r_rdata[p*DATA_WIDTH +: DATA_WIDTH];
  end

  // Lowest violating port and violation popcount for this cycle
  always_comb begin
    first_port_s = 4'd0;
    first_addr_s = 32'd0;
    first_wen_s  = 1'b0;
    viol_cnt_s   = 5'd0;
    for (int p = N_PORTS - 1; p >= 0; p--) begin
      first_port_s = viol_s[p] ? 4'(p) : first_port_s;
      first_addr_s = viol_s[p] ? 32'(mst_bus.add[p*ADDR_WIDTH +: ADDR_WIDTH]) : first_addr_s;
      first_wen_s  = viol_s[p] ? mst_bus.wen[p] : first_wen_s;
      viol_cnt_s   = viol_cnt_s + 5'(viol_s[p]);
    end
    count_sum_s = {1'b0, err_count_q} + 17'(viol_cnt_s);
  end

  // Next state of the register file and fault log
  always_comb begin
    start_d     = start_q;
    end_d       = end_q;
    ctrl_d      = ctrl_q;
    filter_en_d = filter_en_q;
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    err_port_d  = err_port_q;
    err_wen_d   = err_wen_q;
    err_count_d = count_sum_s[16] ? 16'hFFFF : count_sum_s[15:0];
    for (int r = 0; r < N_RULES; r++) begin
      case ({cfg_we_s & ~glb_sel_s & ~ctrl_q[r][3] & (cfg_add_i[11:4] == 8'(r)), cfg_add_i[3:2]})
        3'b100:  start_d[r] = cfg_wdata_i;
        3'b101:  end_d[r]   = cfg_wdata_i;
        3'b110:  ctrl_d[r]  = cfg_wdata_i[3:0];
        default: ;
      endcase
    end
    if (cfg_we_s && glb_sel_s && (glb_word_s == 6'd0)) begin
      filter_en_d = cfg_wdata_i[0];
    end else begin
      filter_en_d = filter_en_q;
    end
    // A new fault wins over a same-cycle software clear
    if ((|viol_s) && (!err_valid_q || err_clr_s)) begin
      err_valid_d = 1'b1;
      err_addr_d  = first_addr_s;
      err_port_d  = first_port_s;
      err_wen_d   = first_wen_s;
    end else if (err_clr_s) begin
      err_valid_d = 1'b0;
      err_addr_d  = 32'd0;
    end else begin
      err_valid_d = err_valid_q;
    end
  end

  // Config read mux, sampled into the response register on request
  always_comb begin
    cfg_rdata_s = 32'd0;
    if (glb_sel_s) begin
      case (glb_word_s)
        6'd0:    cfg_rdata_s = {31'd0, filter_en_q};
        6'd1:    cfg_rdata_s = err_addr_q;
        6'd2:    cfg_rdata_s = {err_valid_q, 22'd0, err_wen_q, 4'd0, err_port_q};
        6'd3:    cfg_rdata_s = {16'd0, err_count_q};
        default: cfg_rdata_s = 32'd0;
      endcase
`ifdef TCDM_MPU_PORT_CNT_EN
      for (int p = 0; p < N_PORTS; p++) begin
        cfg_rdata_s = (glb_word_s == 6'(4 + p)) ? {16'd0, pcnt_q[p]} : cfg_rdata_s;
      end
`endif
    end else begin
      for (int r = 0; r < N_RULES; r++) begin
        case ({(cfg_add_i[11:4] == 8'(r)), cfg_add_i[3:2]})
          3'b100:  cfg_rdata_s = start_q[r];
          3'b101:  cfg_rdata_s = end_q[r];
          3'b110:  cfg_rdata_s = {28'd0, ctrl_q[r]};
          default: ;
        endcase
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N_RULES; r++) begin
        start_q[r] <= 32'd0;
        end_q[r]   <= 32'd0;
        ctrl_q[r]  <= 4'd0;
      end
      filter_en_q   <= FILTER_EN_RST;
      err_valid_q   <= 1'b0;
      err_addr_q    <= 32'd0;
      err_port_q    <= 4'd0;
      err_wen_q     <= 1'b0;
      err_count_q   <= 16'd0;
      err_pend_q    <= '0;
      cfg_r_valid_q <= 1'b0;
      cfg_rdata_q   <= 32'd0;
    end else begin
      start_q       <= start_d;
      end_q         <= end_d;
      ctrl_q        <= ctrl_d;
      filter_en_q   <= filter_en_d;
      err_valid_q   <= err_valid_d;
      err_addr_q    <= err_addr_d;
      err_port_q    <= err_port_d;
      err_wen_q     <= err_wen_d;
      err_count_q   <= err_count_d;
      err_pend_q    <= viol_s;
      cfg_r_valid_q <= cfg_req_i;
      cfg_rdata_q   <= cfg_req_i ? cfg_rdata_s : cfg_rdata_q;
    end
  end

`ifdef TCDM_MPU_PORT_CNT_EN
  // Per-port saturating counters; a clear loads this cycle's increment
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      pcnt_d[p] = (cfg_we_s && glb_sel_s && (glb_word_s == 6'(4 + p))) ? 16'(viol_s[p])
                : ((pcnt_q[p] == 16'hFFFF) ? pcnt_q[p] : pcnt_q[p] + 16'(viol_s[p]));
    end
  end

  // Per-port counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < N_PORTS; p++) pcnt_q[p] <= 16'd0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end
`endif

  assign cfg_gnt_o     = 1'b1;
  assign cfg_r_valid_o = cfg_r_valid_q;
  assign cfg_r_rdata_o = cfg_rdata_q;
  assign err_irq_o     = err_valid_q;
endmodule

// File: tb/tb_tcdm_mpu_filter.sv
// Directed bench for tcdm_mpu_filter: responses are checked against a
// scoreboard queue filled as requests are driven.
module tb_tcdm_mpu_filter;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] ERR = 32'hBADE5505;

  typedef struct {
    int          port;
    logic [31:0] data;
  } resp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] sup;
  logic          cfg_req, cfg_wen, cfg_gnt, cfg_rv, irq;
  logic [11:0]   cfg_add;
  logic [31:0]   cfg_wdata, cfg_rdata;
  logic [NP-1:0] slv_rv_q;
  int            passed = 0;
  int            total  = 0;
  int            exp_cnt = 0;
  resp_t         sb[$];

  tcdm_mpu_filter_if #(.N_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mst_bus ();
  tcdm_mpu_filter_if #(.N_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) slv_bus ();

  tcdm_mpu_filter #(.N_PORTS(NP), .N_RULES(8), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .supervisor_mode_i(sup),
    .mst_bus(mst_bus), .slv_bus(slv_bus),
    .cfg_req_i(cfg_req), .cfg_add_i(cfg_add), .cfg_wen_i(cfg_wen), .cfg_wdata_i(cfg_wdata),
    .cfg_gnt_o(cfg_gnt), .cfg_r_rdata_o(cfg_rdata), .cfg_r_valid_o(cfg_rv), .err_irq_o(irq)
  );

  always #5 clk = ~clk;

  // Interconnect stand-in: grants every request, answers one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) slv_rv_q <= '0;
    else     slv_rv_q <= slv_bus.req & slv_bus.gnt;
  end
  assign slv_bus.gnt     = slv_bus.req;
  assign slv_bus.r_valid = slv_rv_q;
  for (genvar p = 0; p < NP; p++) begin : g_slv
    assign slv_bus.r_rdata[p*DW +: DW] = 32'h5AFE0000 | 32'(p);
  end

  function automatic logic [31:0] slv_data(input int p);
    return 32'h5AFE0000 | 32'(p);
  endfunction

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    resp_t         e;
    logic [NP-1:0] seen;
    @(posedge clk);
    #1;
    seen = '0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      seen[e.port] = 1'b1;
      chk(32'(mst_bus.r_valid[e.port]), 32'd1, "resp_valid");
      chk(mst_bus.r_rdata[e.port*DW +: DW], e.data, "resp_data");
    end
    chk(32'(mst_bus.r_valid & ~seen), 32'd0, "resp_spurious");
    mst_bus.req = '0;
    cfg_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic acc(input int p, input logic [31:0] a, input logic w, input logic fwd,
                     input string tag);
    resp_t e;
    mst_bus.req[p] = 1'b1;
    mst_bus.add[p*AW +: AW] = a;
    mst_bus.wen[p] = w;
    #1;
    chk(32'(slv_bus.req[p]), 32'(fwd), {tag, "_req_o"});
    chk(32'(mst_bus.gnt[p]), 32'd1, {tag, "_gnt_o"});
    e.port = p;
    e.data = fwd ? slv_data(p) : ERR;
    sb.push_back(e);
  endtask

  task automatic cfg_wr(input logic [11:0] a, input logic [31:0] d);
    cfg_req = 1'b1; cfg_wen = 1'b0; cfg_add = a; cfg_wdata = d;
    tick();
    chk(32'(cfg_rv), 32'd1, "cfg_wr_valid");
  endtask

  task automatic cfg_rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
    cfg_req = 1'b1; cfg_wen = 1'b1; cfg_add = a;
    tick();
    chk(32'(cfg_rv), 32'd1, {tag, "_valid"});
    chk(cfg_rdata, exp, tag);
  endtask

  initial begin
    rst = 1'b1; sup = '0; cfg_req = 1'b0; cfg_wen = 1'b1; cfg_add = 12'd0; cfg_wdata = 32'd0;
    mst_bus.req = '0; mst_bus.add = '0; mst_bus.wen = '1; mst_bus.wdata = '0; mst_bus.be = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk(32'(mst_bus.r_valid), 32'd0, "rst_r_valid");
    chk(32'(cfg_rv), 32'd0, "rst_cfg_r_valid");
    chk(32'(irq), 32'd0, "rst_irq");
    cfg_rd(12'hF00, 32'd0, "rst_filter_en");
    cfg_rd(12'hF08, 32'd0, "rst_err_info");

    // Filter on, empty table: everything blocked
    cfg_wr(12'hF00, 32'd1);
    acc(0, 32'h1C000040, 1'b1, 1'b0, "norule_rd"); tick(); exp_cnt++;
    chk(32'(irq), 32'd1, "irq_set");
    cfg_rd(12'hF08, 32'h80000100, "info_first");
    cfg_rd(12'hF04, 32'h1C000040, "addr_first");

    // Read-only rule 0
    cfg_wr(12'h000, 32'h1C000000);
    cfg_wr(12'h004, 32'h1C001000);
    cfg_wr(12'h008, 32'h00000003);
    acc(0, 32'h1C000FC0, 1'b1, 1'b1, "r0_rd_in");   tick();
    acc(0, 32'h1C000FFC, 1'b1, 1'b1, "r0_rd_last"); tick();
    acc(0, 32'h1C000FC0, 1'b0, 1'b0, "r0_wr_ro");   tick(); exp_cnt++;
    acc(0, 32'h1C001000, 1'b1, 1'b0, "r0_rd_end");  tick(); exp_cnt++;
    acc(0, 32'h1BFFFFC0, 1'b1, 1'b0, "r0_rd_below"); tick(); exp_cnt++;
    cfg_rd(12'hF04, 32'h1C000040, "addr_kept");
    cfg_rd(12'hF0C, 32'(exp_cnt), "count_a");
    cfg_rd(12'h00C, 32'd0, "rule_reserved");
    cfg_rd(12'h0F0, 32'd0, "rule_out_of_range");

    // Clear, then two ports violate together
    cfg_wr(12'hF08, 32'd0);
    chk(32'(irq), 32'd0, "irq_clr");
    cfg_rd(12'hF04, 32'd0, "addr_clr");
    acc(1, 32'h20000000, 1'b0, 1'b0, "p1_wr");
    acc(3, 32'h20000100, 1'b0, 1'b0, "p3_wr");
    acc(0, 32'h1C000100, 1'b1, 1'b1, "p0_fwd");
    tick(); exp_cnt += 2;
    cfg_rd(12'hF08, 32'h80000001, "info_lowest");
    cfg_rd(12'hF04, 32'h20000000, "addr_lowest");
    cfg_rd(12'hF0C, 32'(exp_cnt), "count_b");

    // Back-to-back violations on one port
    acc(2, 32'h30000000, 1'b1, 1'b0, "b2b_0"); tick();
    acc(2, 32'h30000040, 1'b1, 1'b0, "b2b_1"); tick(); exp_cnt += 2;

    // Supervisor bypass
    sup[0] = 1'b1;
    acc(0, 32'h1C000000, 1'b0, 1'b1, "sup_wr"); tick();
    sup[0] = 1'b0;
    cfg_rd(12'hF0C, 32'(exp_cnt), "count_sup");

    // Lock on rule 1
    cfg_wr(12'h010, 32'h30000000);
    cfg_wr(12'h018, 32'h0000000F);
    cfg_wr(12'h010, 32'h00000000);
    cfg_wr(12'h018, 32'h00000000);
    cfg_rd(12'h010, 32'h30000000, "lock_start");
    cfg_rd(12'h018, 32'h0000000F, "lock_ctrl");

    // Reset while an error response is pending
    acc(0, 32'h40000000, 1'b1, 1'b0, "pre_rst");
    @(posedge clk);
    #1;
    chk(32'(mst_bus.r_valid[0]), 32'd1, "pend_before_rst");
    sb.delete();
    rst = 1'b1;
    #1;
    chk(32'(mst_bus.r_valid), 32'd0, "rst_drops_resp");
    mst_bus.req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    chk(32'(irq), 32'd0, "rst2_irq");
    cfg_rd(12'h010, 32'd0, "rst2_start");
    cfg_rd(12'h018, 32'd0, "rst2_ctrl");
    cfg_rd(12'hF0C, 32'd0, "rst2_count");

    // Single port-2 violation and its per-port counter
    cfg_wr(12'hF00, 32'd1);
    acc(2, 32'h50000000, 1'b0, 1'b0, "p2_cnt"); tick(); exp_cnt++;
    cfg_rd(12'hF08, 32'h80000002, "info_p2");
`ifdef TCDM_MPU_PORT_CNT_EN
    cfg_rd(12'hF18, 32'd1, "port2_cnt");
`else
    cfg_rd(12'hF18, 32'd0, "port2_cnt_absent");
`endif

    // Drive ERR_COUNT to exactly 0xFFFF, then past it
    for (int i = 0; i < 16383; i++) begin
      for (int p = 0; p < NP; p++) acc(p, 32'h60000000, 1'b1, 1'b0, "fill");
      tick();
    end
    acc(0, 32'h60000000, 1'b1, 1'b0, "fill_a");
    acc(1, 32'h60000000, 1'b1, 1'b0, "fill_b");
    tick();
    exp_cnt += 16383 * NP + 2;
    cfg_rd(12'hF0C, 32'(exp_cnt), "count_max");
    cfg_req = 1'b1; cfg_wen = 1'b0; cfg_add = 12'hF08; cfg_wdata = 32'hFFFFFFFF;
    acc(2, 32'h70000040, 1'b1, 1'b0, "clr_and_viol");
    tick();
    cfg_rd(12'hF0C, 32'h0000FFFF, "count_sat");
    cfg_rd(12'hF08, 32'h80000102, "info_clr_race");
    cfg_rd(12'hF04, 32'h70000040, "addr_clr_race");
    chk(32'(cfg_gnt), 32'd1, "cfg_gnt");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/tcdm_mpu_filter.md
Name: tcdm_mpu_filter

Overview:
- Multi-port TCDM address filter (memory protection unit) placed between N_PORTS TCDM masters and the L2/cluster interconnect.
- Holds an internal rule table of start/end/permission registers, programmed at runtime through a TCDM-style config slave port.
- Blocks disallowed accesses and answers them locally with an error pattern.
- Logs the first fault (address, port, type) and counts violations.

Parameters:
- N_PORTS, 4, number of filtered master channels (1..16).
- N_RULES, 8, number of rule entries (1..64).
- ADDR_WIDTH, 32, master address width.
- DATA_WIDTH, 32, master data width; must be a multiple of 32.
- BE_WIDTH, DATA_WIDTH/8, byte enables.
- GRAN_LOG2, 6, rule granularity; only address bits [ADDR_WIDTH-1:GRAN_LOG2] are compared.
- ERR_PATTERN, 32'hBADE5505, read data returned on a blocked access, replicated DATA_WIDTH/32 times.
- FILTER_EN_RST, 1'b0, reset value of GLOBAL_CTRL.filter_en.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- supervisor_mode_i  in  N_PORTS  per-port bypass: a violation is forwarded, with no error
- req_i  in  N_PORTS  master request
- add_i  in  N_PORTS*ADDR_WIDTH  address
- wen_i  in  N_PORTS  1=read, 0=write
- wdata_i  in  N_PORTS*DATA_WIDTH  write data
- be_i  in  N_PORTS*BE_WIDTH  byte enables
- gnt_o  out  N_PORTS  grant to master
- r_rdata_o  out  N_PORTS*DATA_WIDTH  response data
- r_valid_o  out  N_PORTS  response valid
- req_o / add_o / wen_o / wdata_o / be_o  out  same widths  forwarded request
- gnt_i / r_rdata_i / r_valid_i  in  same widths  slave-side grant and response
- cfg_req_i  in  1  config request
- cfg_add_i  in  12  config byte address
- cfg_wen_i  in  1  1=read, 0=write
- cfg_wdata_i  in  32  config write data
- cfg_gnt_o  out  1  config grant; tied to 1
- cfg_r_rdata_o  out  32  config read data
- cfg_r_valid_o  out  1  config response valid
- err_irq_o  out  1  level interrupt; equals ERR_INFO.valid

Behaviour:
- Register map (32-bit words):
  - Rule r at 0x000+16r: START (+0), END (+4, exclusive), CTRL (+8).
  - CTRL bits: [0] enable, [1] allow_read, [2] allow_write, [3] lock.
  - Global registers:
    - 0xF00 GLOBAL_CTRL: [0] filter_en.
    - 0xF04 ERR_ADDR.
    - 0xF08 ERR_INFO: [31] valid, [8] wen, [3:0] port.
    - 0xF0C ERR_COUNT: 16-bit, saturating.
  - Unmapped and reserved bits read 0; writes to them are ignored.
- Reset values: all rule registers 0; filter_en=FILTER_EN_RST; ERR_* = 0.
- Reset values of outputs: r_valid_o=0, cfg_r_valid_o=0, err_irq_o=0. Comb outputs follow their inputs.
- Config port:
  - Grant always 1.
  - Response arrives 1 cycle after the request, for both reads and writes: cfg_r_valid_o=1. Read data is the register value sampled at request time.
  - Writes take effect on the next cycle.
  - If a rule's lock=1, writes to that rule's START/END/CTRL are ignored until reset.
  - Writing any value to ERR_INFO clears valid and ERR_ADDR.
- Match rule: rule r matches port p when enable=1 and START[AW-1:G] <= add[AW-1:G] < END[AW-1:G].
  - END <= START means an empty rule.
  - The compare is unsigned, with no wrap.
- Access allowed:
  - filter_en=0, or
  - any matching rule grants the access type (allow_read for wen=1, allow_write for wen=0), or
  - supervisor_mode_i[p]=1.
- Allowed access:
  - Request path is pure combinational pass-through: req_o=req_i, gnt_o=gnt_i.
  - Response path forwards r_rdata_i and r_valid_i, unless an error response is pending.
- Violation (req_i[p]=1 and not allowed):
  - Same cycle: req_o[p]=0, gnt_o[p]=1.
  - Next cycle: r_valid_o[p]=1, r_rdata_o[p]=ERR_PATTERN; r_valid_i[p] is ignored in that cycle.
- Back-to-back violations on a port produce back-to-back error responses, one per cycle.
- Error capture:
  - When ERR_INFO.valid=0, the lowest-index violating port that cycle is logged and valid is set.
  - Later faults are not logged until software clears valid.
  - A clear and a new violation in the same cycle: the new violation is logged.
- ERR_COUNT adds the popcount of violating ports each cycle and saturates at 0xFFFF.
- Reset asserted mid-operation: pending error responses are dropped and all state returns to reset values.

Optional Feature:
- Macro: TCDM_MPU_PORT_CNT_EN.
- Defined:
  - Per-port 16-bit saturating violation counters, readable at 0xF10+4p.
  - Any write clears the addressed counter.
  - A clear and an increment in the same cycle: the counter loads the increment value.
- Undefined: no counters; 0xF10..0xF4C read 0.

Test Plan:
- Reset, filter_en=1, no rules, port0 read 0x1C000040 -> gnt_o[0]=1, req_o[0]=0; next cycle r_rdata_o[0]=0xBADE5505, r_valid_o[0]=1; ERR_INFO=0x80000100 (valid, wen=1, port 0), ERR_ADDR=0x1C000040, err_irq_o=1.
- Rule0 START=0x1C000000, END=0x1C001000, CTRL=0x3 (read-only):
  - read 0x1C000FC0 -> forwarded.
  - write 0x1C000FC0 -> blocked.
  - read 0x1C001000 -> blocked (END exclusive).
- Ports 1 and 3 violate in the same cycle with ERR_INFO clear -> port 1 logged, ERR_COUNT += 2; next cycle error responses on both ports.
- Rule1 CTRL=0xF (lock set), then write START=0 -> readback unchanged; rst pulse -> rule1 reads 0.
- ERR_COUNT preloaded by 65535 violations, then one more -> holds 0xFFFF. Write ERR_INFO in the same cycle as a port2 violation -> ERR_INFO.valid=1, port=2.
- Supervisor_mode_i[0]=1 with a violating write -> forwarded, no error, ERR_COUNT unchanged. With TCDM_MPU_PORT_CNT_EN: a port-2 violation makes 0xF18 read 1.
